// File: rtl/dtree_seq_engine_if.sv
// Bus bundle for the sequential decision-tree engine: node-table config port,
// feature-vector input stream and class-result output stream.
interface dtree_seq_engine_if #(
  parameter int N_FEAT    = 5,
  parameter int FEAT_W    = 8,
  parameter int N_NODES   = 64,
  parameter int CLASS_W   = 1,
  parameter int MAX_STEPS = 16
);
  localparam int AW     = $clog2(N_NODES);
  localparam int FI     = $clog2(N_FEAT);
  localparam int KW     = $clog2(FEAT_W + 1);
  localparam int NODE_W = 1 + FI + KW + FEAT_W + 2 * AW;
  localparam int SW     = $clog2(MAX_STEPS + 1);

  // A transfer happens on a rising edge where valid && ready; the source holds
  // its payload stable while valid is high and ready is low.
  logic                     cfg_we;
  logic [AW-1:0]            cfg_addr;
  logic [NODE_W-1:0]        cfg_data;
  logic                     in_valid;
  logic                     in_ready;
  logic [N_FEAT*FEAT_W-1:0] in_feat;
  logic                     out_valid;
  logic                     out_ready;
  logic [CLASS_W-1:0]       out_class;
  logic                     out_err;
  logic [SW-1:0]            out_steps;

  modport master (
    output cfg_we, cfg_addr, cfg_data, in_valid, in_feat, out_ready,
    input  in_ready, out_valid, out_class, out_err, out_steps
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, in_valid, in_feat, out_ready,
    output in_ready, out_valid, out_class, out_err, out_steps
  );
endinterface

// File: rtl/dtree_seq_engine.sv
// Sequential decision-tree classifier: one shared comparator walks a loadable
// node table one node per clock until a leaf or the step limit is reached.
module dtree_seq_engine #(
  parameter int N_FEAT    = 5,
  parameter int FEAT_W    = 8,
  parameter int N_NODES   = 64,
  parameter int CLASS_W   = 1,
  parameter int MAX_STEPS = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  dtree_seq_engine_if.slave  bus,
  output logic [1:0]         o_dbg_state
);
  localparam int AW     = $clog2(N_NODES);
  localparam int FI     = $clog2(N_FEAT);
  localparam int KW     = $clog2(FEAT_W + 1);
  localparam int NODE_W = 1 + FI + KW + FEAT_W + 2 * AW;
  localparam int SW     = $clog2(MAX_STEPS + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WALK = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                   r_state;
  logic [NODE_W-1:0]        r_mem [N_NODES];
  logic [N_FEAT*FEAT_W-1:0] r_feat;
  logic [AW-1:0]            r_ptr;
  logic [SW-1:0]            r_steps;
  logic                     r_in_ready;
  logic                     r_out_valid;
  logic [CLASS_W-1:0]       r_class;
  logic                     r_err;

  logic [NODE_W-1:0] w_node;
  logic              w_leaf;
  logic [FI-1:0]     w_fidx;
  logic [KW-1:0]     w_keep;
  logic [KW-1:0]     w_k;
  logic [KW-1:0]     w_shamt;
  logic [FEAT_W-1:0] w_thr;
  logic [AW-1:0]     w_left;
  logic [AW-1:0]     w_right;
  logic [FEAT_W-1:0] w_feat;
  logic [FEAT_W-1:0] w_v;
  logic [SW-1:0]     w_steps_nx;
  logic              w_accept;
  logic              w_cfg_ok;

  assign w_node  = r_mem[r_ptr];
  assign w_leaf  = w_node[NODE_W-1];
  assign w_fidx  = w_node[NODE_W-2 -: FI];
  assign w_keep  = w_node[NODE_W-2-FI -: KW];
  assign w_thr   = w_node[2*AW +: FEAT_W];
  assign w_left  = w_node[AW +: AW];
  assign w_right = w_node[0 +: AW];

  // keep is clamped to FEAT_W; keep=0 shifts the whole feature out (v=0).
  assign w_k        = (w_keep > KW'(FEAT_W)) ? KW'(FEAT_W) : w_keep;
  assign w_shamt    = KW'(FEAT_W) - w_k;
  assign w_v        = w_feat >> w_shamt;
  assign w_steps_nx = r_steps + SW'(1);

  // Feature indices past N_FEAT match no slot and read as zero.
  always_comb begin
    w_feat = '0;
    for (int f = 0; f < N_FEAT; f++) begin
      if (w_fidx == FI'(f)) w_feat = r_feat[f*FEAT_W +: FEAT_W];
    end
  end

  assign w_accept = bus.in_valid && r_in_ready;
  assign w_cfg_ok = (r_state == S_IDLE) && bus.cfg_we && (int'(bus.cfg_addr) < N_NODES);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NODES; i++) r_mem[i] <= '0;
    end else if (w_cfg_ok) begin
      r_mem[bus.cfg_addr] <= bus.cfg_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_feat      <= '0;
      r_ptr       <= '0;
      r_steps     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_class     <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_feat     <= bus.in_feat;
            r_ptr      <= '0;
            r_steps    <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_WALK;
          end
        end
        S_WALK: begin
          r_steps <= w_steps_nx;
          if (w_leaf) begin
            r_class     <= w_node[CLASS_W-1:0];
            r_err       <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (w_steps_nx == SW'(MAX_STEPS)) begin
            r_class     <= '0;
            r_err       <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_ptr <= (w_v <= w_thr) ? w_left : w_right;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_class = r_class;
  assign bus.out_err   = r_err;
  assign bus.out_steps = r_steps;
  assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_dtree_seq_engine.sv
// Bench for dtree_seq_engine: directed tree cases plus random tables/vectors,
// scored against a path-walking model of the node table.
module tb_dtree_seq_engine;
  localparam int N_FEAT    = 5;
  localparam int FEAT_W    = 8;
  localparam int N_NODES   = 64;
  localparam int CLASS_W   = 1;
  localparam int MAX_STEPS = 16;
  localparam int AW        = 6;
  localparam int NODE_W    = 28;
  localparam int SW        = 5;
  localparam int EW        = CLASS_W + 1 + SW;
  localparam int XW        = N_FEAT * FEAT_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  dtree_seq_engine_if #(.N_FEAT(N_FEAT), .FEAT_W(FEAT_W), .N_NODES(N_NODES),
                        .CLASS_W(CLASS_W), .MAX_STEPS(MAX_STEPS)) bus ();

  dtree_seq_engine #(.N_FEAT(N_FEAT), .FEAT_W(FEAT_W), .N_NODES(N_NODES),
                     .CLASS_W(CLASS_W), .MAX_STEPS(MAX_STEPS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  logic [NODE_W-1:0] shadow [N_NODES];
  logic [EW-1:0]     exp_q[$];
  int                acc_q[$];
  int                checks = 0;
  int                failures = 0;
  int                cyc = 0;
  int                or_mode = 0;
  bit                seen = 0;
  int                cur_lat = 0;
  logic [EW-1:0]     mon_e;
  logic [CLASS_W-1:0] last_cls;
  logic              last_err;
  logic [SW-1:0]     last_steps;
  int                last_lat = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic logic [NODE_W-1:0] mk_int(input int fidx, input int keep, input int thr,
                                                input int left, input int right);
    logic [NODE_W-1:0] n;
    n = {1'b0, 3'(fidx), 4'(keep), 8'(thr), 6'(left), 6'(right)};
    return n;
  endfunction

  function automatic logic [NODE_W-1:0] mk_leaf(input int cls);
    logic [NODE_W-1:0] n;
    n = {1'b1, 27'(cls)};
    return n;
  endfunction

  // Follows the tree from node 0 with integer arithmetic: returns {class, err, steps}.
  function automatic logic [EW-1:0] model(input logic [XW-1:0] f);
    int p, fid, keep, thr, k, x, v;
    logic [NODE_W-1:0] n;
    p = 0;
    for (int s = 1; s <= MAX_STEPS; s++) begin
      n = shadow[p];
      if (n[NODE_W-1]) return {n[CLASS_W-1:0], 1'b0, SW'(s)};
      fid  = int'(n[26:24]);
      keep = int'(n[23:20]);
      thr  = int'(n[19:12]);
      k    = (keep > FEAT_W) ? FEAT_W : keep;
      x    = (fid < N_FEAT) ? int'(8'(f >> (fid * FEAT_W))) : 0;
      v    = x / (1 << (FEAT_W - k));
      if (s == MAX_STEPS) return {{CLASS_W{1'b0}}, 1'b1, SW'(MAX_STEPS)};
      p = (v <= thr) ? int'(n[11:6]) : int'(n[5:0]);
    end
    return '0;
  endfunction

  // Compare process: every cycle out_valid is high, the held result must match the model.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      chk("spurious_out_valid", exp_q.size(), 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q[0];
        chk("out_class", bus.out_class, mon_e[EW-1 -: CLASS_W]);
        chk("out_err", bus.out_err, mon_e[SW]);
        chk("out_steps", bus.out_steps, mon_e[SW-1:0]);
        chk("in_ready_busy", bus.in_ready, 0);
        if (!seen) begin
          seen = 1;
          cur_lat = cyc - acc_q[0] + 1;
          chk("latency", cur_lat, int'(mon_e[SW-1:0]) + 1);
        end
        if (bus.out_ready) begin
          last_cls   = bus.out_class;
          last_err   = bus.out_err;
          last_steps = bus.out_steps;
          last_lat   = cur_lat;
          void'(exp_q.pop_front());
          void'(acc_q.pop_front());
          seen = 0;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (or_mode == 0)      bus.out_ready = 1'b1;
    else if (or_mode == 1) bus.out_ready = ($urandom_range(0, 2) != 0);
    else                   bus.out_ready = 1'b0;
  end

  task automatic cfg_write(input int a, input logic [NODE_W-1:0] d, input bit honoured);
    @(negedge clk);
    bus.cfg_we = 1'b1;
    bus.cfg_addr = 6'(a);
    bus.cfg_data = d;
    @(posedge clk);
    #1;
    bus.cfg_we = 1'b0;
    if (honoured) shadow[a] = d;
  endtask

  task automatic send(input logic [XW-1:0] f, input bit do_w, input int wa,
                      input logic [NODE_W-1:0] wd);
    int t;
    t = 0;
    @(negedge clk);
    while (!bus.in_ready) begin
      t++;
      if (t > 600) begin
        chk("in_ready_timeout", t, 0);
        return;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_feat = f;
    if (do_w) begin
      bus.cfg_we = 1'b1;
      bus.cfg_addr = 6'(wa);
      bus.cfg_data = wd;
      shadow[wa] = wd;
    end
    exp_q.push_back(model(f));
    acc_q.push_back(cyc + 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.cfg_we = 1'b0;
    bus.in_feat = XW'({$urandom(), $urandom()});
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 600) begin
      @(posedge clk);
      t++;
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic load_root_split();
    cfg_write(0, mk_int(0, 6, 5, 1, 2), 1);
    cfg_write(1, mk_leaf(1), 1);
    cfg_write(2, mk_leaf(0), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int t;
    bus.cfg_we = 0; bus.cfg_addr = '0; bus.cfg_data = '0;
    bus.in_valid = 0; bus.in_feat = '0; bus.out_ready = 1;
    for (int i = 0; i < N_NODES; i++) shadow[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_class", bus.out_class, 0);
    chk("rst_out_err", bus.out_err, 0);
    chk("rst_out_steps", bus.out_steps, 0);
    rst_n = 1'b1;

    // Unprogrammed table: node 0 loops on itself until the step limit.
    send(40'h12_3456_789A, 0, 0, '0);
    drain();
    chk("reset_table_err", last_err, 1);
    chk("reset_table_class", last_cls, 0);
    chk("reset_table_steps", last_steps, 16);
    chk("reset_table_latency", last_lat, 17);

    load_root_split();
    send(40'h17, 0, 0, '0);
    drain();
    chk("root_v5_class", last_cls, 1);
    chk("root_v5_steps", last_steps, 2);
    chk("root_v5_latency", last_lat, 3);
    send(40'h18, 0, 0, '0);
    drain();
    chk("root_v6_class", last_cls, 0);
    chk("root_v6_steps", last_steps, 2);

    cfg_write(0, mk_int(1, 2, 1, 3, 2), 1);
    cfg_write(3, mk_int(4, 3, 1, 4, 2), 1);
    cfg_write(4, mk_leaf(1), 1);
    send({8'h3F, 8'hFF, 8'hFF, 8'h40, 8'hFF}, 0, 0, '0);
    drain();
    chk("depth3_class", last_cls, 1);
    chk("depth3_steps", last_steps, 3);
    chk("depth3_latency", last_lat, 4);

    cfg_write(0, mk_int(0, 0, 0, 1, 2), 1);
    send(40'hFF_FFFF_FFFF, 0, 0, '0);
    drain();
    chk("keep0_left", last_cls, 1);
    cfg_write(0, mk_int(7, 8, 0, 1, 2), 1);
    send(40'hFF_FFFF_FFFF, 0, 0, '0);
    drain();
    chk("fidx7_zero", last_cls, 1);
    cfg_write(0, mk_int(0, 15, 8'h80, 1, 2), 1);
    send(40'h80, 0, 0, '0);
    drain();
    chk("keep15_eq", last_cls, 1);
    send(40'h81, 0, 0, '0);
    drain();
    chk("keep15_gt", last_cls, 0);

    // Backpressure: stall DONE, try a write that must be dropped.
    load_root_split();
    or_mode = 2;
    send(40'h17, 0, 0, '0);
    t = 0;
    while (!bus.out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("stall_reach_done", bus.out_valid, 1);
    cfg_write(1, mk_leaf(0), 0);
    repeat (10) @(negedge clk);
    chk("stall_in_ready", bus.in_ready, 0);
    chk("stall_valid_held", bus.out_valid, 1);
    or_mode = 0;
    drain();
    chk("stall_class", last_cls, 1);
    send(40'h17, 0, 0, '0);
    drain();
    chk("stall_write_dropped", last_cls, 1);

    // Random tables and vectors with random backpressure and accept-cycle writes.
    for (int a = 0; a < N_NODES; a++) begin
      if ($urandom_range(0, 2) == 0) cfg_write(a, mk_leaf(int'($urandom_range(0, 1))), 1);
      else cfg_write(a, mk_int(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                               int'($urandom_range(0, 255)), int'($urandom_range(0, 63)),
                               int'($urandom_range(0, 63))), 1);
    end
    or_mode = 1;
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 3) == 0)
        send(XW'({$urandom(), $urandom()}), 1, int'($urandom_range(0, 63)),
             ($urandom_range(0, 1) != 0) ? mk_leaf(int'($urandom_range(0, 1)))
             : mk_int(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 255)), int'($urandom_range(0, 63)),
                      int'($urandom_range(0, 63))));
      else
        send(XW'({$urandom(), $urandom()}), 0, 0, '0);
    end
    drain();
    or_mode = 0;

    // Reset during the second walk cycle of a 3-node path.
    cfg_write(0, mk_int(0, 0, 0, 1, 1), 1);
    cfg_write(1, mk_int(0, 0, 0, 2, 2), 1);
    cfg_write(2, mk_leaf(1), 1);
    send(40'h55, 0, 0, '0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    seen = 0;
    for (int i = 0; i < N_NODES; i++) shadow[i] = '0;
    repeat (3) @(negedge clk);
    chk("midrst_out_valid", bus.out_valid, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("midrst_no_result", bus.out_valid, 0);
      chk("midrst_in_ready", bus.in_ready, 1);
    end
    send(40'h55, 0, 0, '0);
    drain();
    chk("midrst_cleared_err", last_err, 1);
    chk("midrst_cleared_steps", last_steps, 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
